// File: rtl/read_ptr_empty_logic.sv
// Read-side pointer, empty flag and fill level for a two-flop-sync async FIFO.
// Optional sticky underflow detection is built when RD_UNDERFLOW_EN is defined.
module read_ptr_empty_logic #(
    parameter int address = 2
) (
    input  logic               rclk,
    input  logic               rreset,
    input  logic               ren,
    input  logic [address:0]   write_ptr_gray,
    output logic [address:0]   read_ptr,
    output logic [address:0]   read_ptr_gray,
    output logic               rd_fire,
    output logic               empty,
    output logic [address:0]   rd_level,
    output logic               underflow
);

    logic [address:0] wq1;
    logic [address:0] wq2;
    logic [address:0] rbin;
    logic [address:0] rgray;
    logic [address:0] rbin_next;
    logic [address:0] rgray_next;
    logic [address:0] wbin_s;
    logic             empty_q;
    logic [address:0] level_q;

    function automatic logic [address:0] gray2bin(input logic [address:0] g);
        logic [address:0] b;
        b[address] = g[address];
        for (int i = address - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign rd_fire    = ren & ~empty_q;
    assign rbin_next  = rbin + {{address{1'b0}}, rd_fire};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    assign wbin_s     = gray2bin(wq2);

    // Only wq2 feeds downstream logic; wq1 is the metastability stage.
    always_ff @(posedge rclk) begin
        if (rreset) begin
            wq1     <= '0;
            wq2     <= '0;
            rbin    <= '0;
            rgray   <= '0;
            empty_q <= 1'b1;
            level_q <= '0;
        end else begin
            wq1     <= write_ptr_gray;
            wq2     <= wq1;
            rbin    <= rbin_next;
            rgray   <= rgray_next;
            empty_q <= (rgray_next == wq2);
            level_q <= wbin_s - rbin_next;
        end
    end

    assign read_ptr      = rbin;
    assign read_ptr_gray = rgray;
    assign empty         = empty_q;
    assign rd_level      = level_q;

`ifdef RD_UNDERFLOW_EN
    logic       uf_q;
    logic [7:0] uf_cnt;

    always_ff @(posedge rclk) begin
        if (rreset) begin
            uf_q   <= 1'b0;
            uf_cnt <= '0;
        end else begin
            uf_q <= uf_q | (ren & empty_q);
            if (ren && empty_q && (uf_cnt != 8'hFF)) begin
                uf_cnt <= uf_cnt + 8'd1;
            end
        end
    end

    assign underflow = uf_q;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_read_ptr_empty_logic.sv
// Testbench for read_ptr_empty_logic: directed steps plus random traffic
// checked against an entry-count model of the read side.
module tb_read_ptr_empty_logic;

    localparam int A = 2;
    localparam int PW = A + 1;
    localparam int MOD = 1 << PW;

    logic          rclk;
    logic          rreset;
    logic          ren;
    logic [A:0]    write_ptr_gray;
    logic [A:0]    read_ptr;
    logic [A:0]    read_ptr_gray;
    logic          rd_fire;
    logic          empty;
    logic [A:0]    rd_level;
    logic          underflow;

    int tests = 0;
    int fails = 0;

    // Model: counts of entries written (as driven) and read, plus the
    // write counts still travelling through the two-edge visibility delay.
    int  m_reads;
    int  wcnt;
    int  wdelay[$];
    bit  m_empty;
    bit  m_uf;
    bit  m_init;

    read_ptr_empty_logic #(.address(A)) dut (
        .rclk           (rclk),
        .rreset         (rreset),
        .ren            (ren),
        .write_ptr_gray (write_ptr_gray),
        .read_ptr       (read_ptr),
        .read_ptr_gray  (read_ptr_gray),
        .rd_fire        (rd_fire),
        .empty          (empty),
        .rd_level       (rd_level),
        .underflow      (underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [A:0] to_gray(input int n);
        int b;
        b = n % MOD;
        return PW'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit rs);
        int vis;
        bit fire;
        int lvl;
        ren = r;
        rreset = rs;
        write_ptr_gray = to_gray(wcnt);
        #1;
        if (m_init) chk("rd_fire", 32'(rd_fire), 32'(r && !m_empty));
        fire = r && !m_empty;
        @(posedge rclk);
        if (rs) begin
            m_reads = 0;
            m_empty = 1'b1;
            m_uf = 1'b0;
            wdelay = '{0, 0};
            m_init = 1'b1;
            lvl = 0;
        end else begin
`ifdef RD_UNDERFLOW_EN
            if (r && m_empty) m_uf = 1'b1;
`endif
            if (fire) m_reads++;
            vis = wdelay.pop_front();
            wdelay.push_back(wcnt);
            lvl = vis - m_reads;
            m_empty = (lvl == 0);
        end
        #1;
        chk("empty", 32'(empty), 32'(m_empty));
        chk("rd_level", 32'(rd_level), 32'(lvl));
        chk("read_ptr", 32'(read_ptr), 32'(m_reads % MOD));
        chk("read_ptr_gray", 32'(read_ptr_gray), 32'(to_gray(m_reads)));
        chk("underflow", 32'(underflow), 32'(m_uf));
    endtask

    initial begin
        m_init = 1'b0;
        m_reads = 0;
        m_empty = 1'b1;
        m_uf = 1'b0;
        wdelay = '{0, 0};
        // Reset held two edges with ren=1 and a non-zero write pointer
        wcnt = 2;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        chk("reset_ptr", 32'(read_ptr), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);

        // Sync latency: 000 -> 001
        wcnt = 0;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        wcnt = 1;
        cycle(1'b0, 1'b0);
        chk("sync_e1", 32'(empty), 32'd1);
        cycle(1'b0, 1'b0);
        chk("sync_e2", 32'(empty), 32'd1);
        cycle(1'b0, 1'b0);
        chk("sync_e3", 32'(empty), 32'd0);
        chk("sync_lvl", 32'(rd_level), 32'd1);

        // Drain four entries, fifth read ignored
        wcnt = 0;
        cycle(1'b0, 1'b1);
        wcnt = 4;
        repeat (3) cycle(1'b0, 1'b0);
        chk("drain_full", 32'(rd_level), 32'd4);
        repeat (4) cycle(1'b1, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_gray", 32'(read_ptr_gray), 32'b110);
        cycle(1'b1, 1'b0);
        chk("drain_hold", 32'(read_ptr), 32'd4);

        // Underflow: ren while empty
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
`ifdef RD_UNDERFLOW_EN
        chk("uf_sticky", 32'(underflow), 32'd1);
`else
        chk("uf_off", 32'(underflow), 32'd0);
`endif

        // Nine write/read pairs across the pointer wrap
        for (int i = 0; i < 9; i++) begin
            wcnt++;
            repeat (3) cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
        chk("wrap_ptr", 32'(read_ptr), 32'd5);

        // Random traffic with a legal writer
        for (int i = 0; i < 400; i++) begin
            if ((wcnt - m_reads) < (1 << A) && ($urandom_range(1, 0) == 1))
                wcnt++;
            cycle(($urandom_range(2, 0) != 0), 1'b0);
        end

        // Reset mid-stream with three entries pending
        wcnt += 3;
        repeat (6) cycle(1'b0, 1'b0);
        if (m_empty) begin
            wcnt += 3;
            repeat (3) cycle(1'b0, 1'b0);
        end
        wcnt = 3;
        cycle(1'b1, 1'b1);
        chk("mid_rst_ptr", 32'(read_ptr), 32'd0);
        chk("mid_rst_lvl", 32'(rd_level), 32'd0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("mid_e2", 32'(empty), 32'd1);
        cycle(1'b0, 1'b0);
        chk("mid_e3", 32'(empty), 32'd0);
        chk("mid_lvl3", 32'(rd_level), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
